network_owner_sched: RTL and testbench

NETWORK_OWNER_SCHED -- requirements
Module: network_owner_sched

---
 rtl/network_owner_sched_pkg.sv | 27 ++
 rtl/network_owner_sched_rr_pick.sv | 28 ++
 rtl/network_owner_sched.sv | 149 ++++++++++++++
 tb/tb_network_owner_sched.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/network_owner_sched_pkg.sv
// Shared types and constants for the network ownership scheduler.
package network_owner_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SWITCH = 2'd1,
    S_GRANT  = 2'd2,
    S_DRAIN  = 2'd3
  } sched_state_t;

  localparam logic [31:0] STATE_REG_TRUSTED   = 32'h0000_0001;
  localparam logic [31:0] STATE_REG_UNTRUSTED = 32'h0000_0000;

  function automatic logic [31:0] state_reg_value(input logic is_trusted);
    return is_trusted ? STATE_REG_TRUSTED : STATE_REG_UNTRUSTED;
  endfunction

  // Index of the (single) set bit of a one-hot vector, 0 when empty.
  function automatic int oh_to_idx(input logic [31:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++)
      if (oh[i]) idx = i;
    return idx;
  endfunction

endpackage

// File: rtl/network_owner_sched_rr_pick.sv
// Round-robin picker: first requester strictly after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner_oh,
  output logic          valid
);

  logic [PW-1:0] idx;

  always_comb begin
    winner_oh = '0;
    valid     = 1'b0;
    idx       = '0;
    // i runs 1..N so the pointer itself is searched last
    for (int i = 1; i <= N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!valid && req[idx]) begin
        valid          = 1'b1;
        winner_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/network_owner_sched.sv
// Network ownership scheduler: round-robin hand-off with trusted/untrusted state writes.
// Optional NET_SCHED_DRAIN_TIMEOUT_EN forces DRAIN exit after DRAIN_TIMEOUT busy cycles.
module network_owner_sched
  import network_owner_sched_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int TRUSTED_ID    = 0,
  parameter int MAX_HOLD      = 256,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] rel_pulse,
  input  logic             net_busy,
  output logic [N_REQ-1:0] gnt,
  output logic             state_wr_en,
  output logic [31:0]      state_wr_value,
  output logic             trusted,
  output logic             drain_timeout_err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [PW-1:0] TID      = PW'(TRUSTED_ID);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

  if (N_REQ < 1 || N_REQ > 32 || MAX_HOLD < 1 || DRAIN_TIMEOUT < 1 ||
      TRUSTED_ID < 0 || TRUSTED_ID >= N_REQ) begin : g_param_check
    $error("network_owner_sched: illegal parameter set");
  end

  sched_state_t     state_q, state_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [N_REQ-1:0] gnt_d, owner_oh, pick_oh;
  logic             pick_vld, trusted_d, wr_en_d;
  logic [31:0]      wr_val_d;

`ifdef NET_SCHED_DRAIN_TIMEOUT_EN
  localparam int DW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);
  logic [DW-1:0] drain_q, drain_d;
  logic          err_d;
`endif

  // owner_q doubles as the round-robin pointer (last owner)
  rr_pick #(.N(N_REQ), .PW(PW)) u_rr_pick (
    .req       (req),
    .ptr       (owner_q),
    .winner_oh (pick_oh),
    .valid     (pick_vld)
  );

  assign owner_oh = N_REQ'(1) << owner_q;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    hold_d   = hold_q;
    gnt_d    = gnt;
    trusted_d = trusted;
    wr_en_d  = 1'b0;
    wr_val_d = state_wr_value;
`ifdef NET_SCHED_DRAIN_TIMEOUT_EN
    drain_d  = drain_q;
    err_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d  = S_SWITCH;
          owner_d  = PW'(oh_to_idx(32'(pick_oh)));
          wr_en_d  = 1'b1;
          wr_val_d = state_reg_value(owner_d == TID);
        end
      end
      S_SWITCH: begin
        state_d   = S_GRANT;
        gnt_d     = owner_oh;
        trusted_d = (owner_q == TID);
        hold_d    = '0;
      end
      S_GRANT: begin
        // release and hold expiry share one branch, so only one DRAIN entry
        if (rel_pulse[owner_q] || !req[owner_q] ||
            (hold_q == HOLD_MAX && |(req & ~owner_oh))) begin
          state_d   = S_DRAIN;
          gnt_d     = '0;
          trusted_d = 1'b0;
`ifdef NET_SCHED_DRAIN_TIMEOUT_EN
          drain_d   = '0;
`endif
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (!net_busy) state_d = S_IDLE;
`ifdef NET_SCHED_DRAIN_TIMEOUT_EN
        else if (drain_q == DRAIN_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else drain_d = drain_q + 1'b1;
`endif
        if (state_d == S_IDLE) begin
          wr_en_d  = 1'b1;
          wr_val_d = STATE_REG_UNTRUSTED;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      owner_q        <= PW'(N_REQ - 1);
      hold_q         <= '0;
      gnt            <= '0;
      trusted        <= 1'b0;
      state_wr_en    <= 1'b0;
      state_wr_value <= STATE_REG_UNTRUSTED;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      hold_q         <= hold_d;
      gnt            <= gnt_d;
      trusted        <= trusted_d;
      state_wr_en    <= wr_en_d;
      state_wr_value <= wr_val_d;
    end
  end

`ifdef NET_SCHED_DRAIN_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_q           <= '0;
      drain_timeout_err <= 1'b0;
    end else begin
      drain_q           <= drain_d;
      drain_timeout_err <= err_d;
    end
  end
`else
  assign drain_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_network_owner_sched.sv
// Self-checking bench for network_owner_sched: vector table plus hand-written corner sequences.
module tb_network_owner_sched;
  import network_owner_sched_pkg::*;

  localparam int N = 4;
  localparam logic [31:0] T = 32'h1;
  localparam logic [31:0] U = 32'h0;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] rel;
    logic         busy;
    logic [N-1:0] gnt;
    logic         wr_en;
    logic [31:0]  wr_val;
    logic         trusted;
    logic         err;
  } vec_t;

  typedef struct {
    string        tag;
    logic [N-1:0] gnt;
    logic         wr_en;
    logic [31:0]  wr_val;
    logic         trusted;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, rel_pulse, gnt;
  logic         net_busy, state_wr_en, trusted, drain_timeout_err;
  logic [31:0]  state_wr_value;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  network_owner_sched #(
    .N_REQ(N), .TRUSTED_ID(0), .MAX_HOLD(8), .DRAIN_TIMEOUT(64)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req               (req),
    .rel_pulse         (rel_pulse),
    .net_busy          (net_busy),
    .gnt               (gnt),
    .state_wr_en       (state_wr_en),
    .state_wr_value    (state_wr_value),
    .trusted           (trusted),
    .drain_timeout_err (drain_timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_outputs(input exp_t e);
    chk({e.tag, ".gnt"},     32'(gnt),               32'(e.gnt));
    chk({e.tag, ".wr_en"},   32'(state_wr_en),       32'(e.wr_en));
    chk({e.tag, ".wr_val"},  state_wr_value,         e.wr_val);
    chk({e.tag, ".trusted"}, 32'(trusted),           32'(e.trusted));
    chk({e.tag, ".err"},     32'(drain_timeout_err), 32'(e.err));
  endtask

  // Drive one cycle of inputs, queue the expectation, compare just after the edge.
  task automatic step(input string tag, input logic [N-1:0] r, input logic [N-1:0] rl,
                      input logic b, input logic [N-1:0] eg, input logic ew,
                      input logic [31:0] ev, input logic et, input logic ee);
    exp_t e;
    req = r; rel_pulse = rl; net_busy = b;
    e.tag = tag; e.gnt = eg; e.wr_en = ew; e.wr_val = ev; e.trusted = et; e.err = ee;
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s scoreboard empty", tag);
    end else chk_outputs(sb.pop_front());
    rel_pulse = '0;
  endtask

  vec_t vt[$];

  initial begin
    exp_t rst_exp;
    rst_exp.gnt = '0; rst_exp.wr_en = 1'b0; rst_exp.wr_val = U;
    rst_exp.trusted = 1'b0; rst_exp.err = 1'b0;

    rst = 1'b1; req = '0; rel_pulse = '0; net_busy = 1'b0;
    #2;
    rst_exp.tag = "reset"; chk_outputs(rst_exp);
    #10;
    rst = 1'b0;

    // Trusted first owner, drain, then round-robin to 1, non-owner release, then 2
    vt.push_back('{4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b1, T, 1'b0, 1'b0});
    vt.push_back('{4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, T, 1'b1, 1'b0});
    vt.push_back('{4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, T, 1'b1, 1'b0});
    vt.push_back('{4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b0, T, 1'b1, 1'b0});
    vt.push_back('{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, T, 1'b0, 1'b0});
    vt.push_back('{4'b0110, 4'b0010, 1'b1, 4'b0000, 1'b0, T, 1'b0, 1'b0});
    vt.push_back('{4'b0110, 4'b0000, 1'b0, 4'b0000, 1'b1, U, 1'b0, 1'b0});
    vt.push_back('{4'b0110, 4'b0000, 1'b0, 4'b0000, 1'b1, U, 1'b0, 1'b0});
    vt.push_back('{4'b0110, 4'b0000, 1'b0, 4'b0010, 1'b0, U, 1'b0, 1'b0});
    vt.push_back('{4'b0110, 4'b0100, 1'b0, 4'b0010, 1'b0, U, 1'b0, 1'b0});
    vt.push_back('{4'b0110, 4'b0010, 1'b0, 4'b0000, 1'b0, U, 1'b0, 1'b0});
    vt.push_back('{4'b0110, 4'b0000, 1'b0, 4'b0000, 1'b1, U, 1'b0, 1'b0});
    vt.push_back('{4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b1, U, 1'b0, 1'b0});
    vt.push_back('{4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b0, U, 1'b0, 1'b0});
    for (int i = 0; i < vt.size(); i++)
      step($sformatf("vec%0d", i), vt[i].req, vt[i].rel, vt[i].busy, vt[i].gnt,
           vt[i].wr_en, vt[i].wr_val, vt[i].trusted, vt[i].err);

    // Owner 2 with domain 0 pending: 8 GRANT cycles total, then 0 wins (3 idle)
    for (int i = 0; i < 7; i++)
      step($sformatf("hold%0d", i), 4'b0101, 4'b0000, 1'b0, 4'b0100, 1'b0, U, 1'b0, 1'b0);
    step("hold_expire", 4'b0101, 4'b0000, 1'b0, 4'b0000, 1'b0, U, 1'b0, 1'b0);
    step("hold_exit",   4'b0101, 4'b0000, 1'b0, 4'b0000, 1'b1, U, 1'b0, 1'b0);
    step("hold_sw0",    4'b0101, 4'b0000, 1'b0, 4'b0000, 1'b1, T, 1'b0, 1'b0);
    step("hold_gnt0",   4'b0101, 4'b0000, 1'b0, 4'b0001, 1'b0, T, 1'b1, 1'b0);

    // Domain 0 alone long past MAX_HOLD: counter saturates, no forced drain
    for (int i = 0; i < 12; i++)
      step($sformatf("sat%0d", i), 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, T, 1'b1, 1'b0);
    // Release coincides with expiry: a single DRAIN, a single exit write
    step("both_drain", 4'b0011, 4'b0001, 1'b0, 4'b0000, 1'b0, T, 1'b0, 1'b0);
    step("both_busy",  4'b0011, 4'b0000, 1'b1, 4'b0000, 1'b0, T, 1'b0, 1'b0);
    step("both_exit",  4'b0011, 4'b0000, 1'b0, 4'b0000, 1'b1, U, 1'b0, 1'b0);
    step("both_idle",  4'b0000, 4'b0001, 1'b0, 4'b0000, 1'b0, U, 1'b0, 1'b0);

    // Domain 3 owns, then a long busy drain
    step("to_sw3",    4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b1, U, 1'b0, 1'b0);
    step("to_gnt3",   4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b0, U, 1'b0, 1'b0);
    step("to_drain3", 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, U, 1'b0, 1'b0);
    for (int k = 1; k <= 100; k++) begin
`ifdef NET_SCHED_DRAIN_TIMEOUT_EN
      if (k == 64)
        step($sformatf("busy%0d", k), 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, U, 1'b0, 1'b1);
      else
        step($sformatf("busy%0d", k), 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, U, 1'b0, 1'b0);
`else
      step($sformatf("busy%0d", k), 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, U, 1'b0, 1'b0);
`endif
    end
`ifdef NET_SCHED_DRAIN_TIMEOUT_EN
    step("busy_done", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, U, 1'b0, 1'b0);
`else
    step("busy_done", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, U, 1'b0, 1'b0);
`endif
    step("busy_idle", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, U, 1'b0, 1'b0);

    // Reset in the middle of a trusted grant to domain 0
    step("pre_sw0",  4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b1, T, 1'b0, 1'b0);
    step("pre_gnt0", 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, T, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 rst_exp.tag = "rst_async"; chk_outputs(rst_exp);
    @(posedge clk); #1;
    rst_exp.tag = "rst_held"; chk_outputs(rst_exp);
    #2 rst = 1'b0;
    step("post_idle", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, U, 1'b0, 1'b0);
    step("post_sw0",  4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b1, T, 1'b0, 1'b0);
    step("post_gnt0", 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, T, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
